// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the CPU peripheral bus.
// Synchronises up to six external interrupt requests. Each request is
// latched as edge- or level-triggered, masked, and driven onto the
// registered CPU hwint lines. Software sees four word registers:
//   PEND (+0x0) W1C, MASK (+0x4), EDGE (+0x8), VEC (+0xC, write = ack lowest).
module irq_ctrl #(
    parameter int          N_SRC = 6,
    parameter logic [31:0] BASE  = 32'h0000_7F30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [31:0]      pr_a,
    input  logic             pr_we,
    input  logic [31:0]      pr_wd,
    output logic [31:0]      pr_rd,
    output logic [5:0]       hwint,
    output logic             irq_any
);

    // Register indices inside the 16-byte window.
    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_VEC  = 2'd3;

    // Lowest-index set bit of v, returned as {valid, idx[2:0]}.
    function automatic logic [3:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [3:0] r;
        r = 4'b0000;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, 3'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Zero-extend a source-wide vector to a 32-bit read word.
    function automatic logic [31:0] pad32(input logic [N_SRC-1:0] v);
        logic [31:0] r;
        r = 32'h0000_0000;
        r[N_SRC-1:0] = v;
        return r;
    endfunction

    // State flops
    logic [N_SRC-1:0] s1_q, s2_q, s3_q;
    logic [N_SRC-1:0] pend_q, mask_q, edge_q;
    logic [5:0]       hwint_q;

    // Next-state values
    logic [N_SRC-1:0] s1_d, s2_d, s3_d;
    logic [N_SRC-1:0] pend_d, mask_d, edge_d;
    logic [5:0]       hwint_d;

    // Decode and helper signals
    logic             sel_s;
    logic [1:0]       reg_idx_s;
    logic             wr_pend_s, wr_mask_s, wr_edge_s, wr_vec_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] active_s;
    logic [3:0]       vec_s;
    logic             vec_valid_s;
    logic [2:0]       vec_idx_s;
    logic [N_SRC-1:0] ack_s;
    logic [N_SRC-1:0] clr_s;

    // Address bits below the word and write-data bits above the sources
    // are intentionally not decoded.
    logic unused_bits_s;
    assign unused_bits_s = ^{pr_a[1:0], pr_wd};

    // Bus decode: window select, register index and per-register write strobes.
    always_comb begin
        sel_s     = (pr_a[31:4] == BASE[31:4]);
        reg_idx_s = pr_a[3:2];
        wr_pend_s = 1'b0;
        wr_mask_s = 1'b0;
        wr_edge_s = 1'b0;
        wr_vec_s  = 1'b0;
        if (pr_we && sel_s) begin
            case (reg_idx_s)
                REG_PEND: wr_pend_s = 1'b1;
                REG_MASK: wr_mask_s = 1'b1;
                REG_EDGE: wr_edge_s = 1'b1;
                REG_VEC:  wr_vec_s  = 1'b1;
                default:  wr_pend_s = 1'b0;
            endcase
        end else begin
            wr_pend_s = 1'b0;
        end
    end

    // Vector register: lowest enabled pending source.
    always_comb begin
        active_s    = pend_q & mask_q;
        vec_s       = lowest_set(active_s);
        vec_valid_s = vec_s[3];
        vec_idx_s   = vec_s[2:0];
    end

    // Clear requests: PEND write-1 plus a one-hot VEC acknowledge.
    always_comb begin
        ack_s = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_vec_s && vec_valid_s && (vec_idx_s == 3'(i))) begin
                ack_s[i] = 1'b1;
            end else begin
                ack_s[i] = 1'b0;
            end
        end
        if (wr_pend_s) begin
            clr_s = pr_wd[N_SRC-1:0] | ack_s;
        end else begin
            clr_s = ack_s;
        end
    end

    // Synchroniser chain; s3 lags s2 by one cycle to detect rising edges.
    always_comb begin
        s1_d   = src_irq;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_s = s2_q & ~s3_q;
    end

    // Pending bits: edge sources set on rise (set beats clear),
    // level sources simply track the synchronised input.
    always_comb begin
        pend_d = (edge_q & (rise_s | (pend_q & ~clr_s))) | (~edge_q & s2_q);
    end

    // Software-written MASK and EDGE registers.
    always_comb begin
        if (wr_mask_s) begin
            mask_d = pr_wd[N_SRC-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (wr_edge_s) begin
            edge_d = pr_wd[N_SRC-1:0];
        end else begin
            edge_d = edge_q;
        end
    end

    // CPU interrupt lines: enabled pending bits, upper lines tied low.
    always_comb begin
        hwint_d = 6'b00_0000;
        hwint_d[N_SRC-1:0] = pend_q & mask_q;
    end

    // All state flops, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= {N_SRC{1'b0}};
            s2_q    <= {N_SRC{1'b0}};
            s3_q    <= {N_SRC{1'b0}};
            pend_q  <= {N_SRC{1'b0}};
            mask_q  <= {N_SRC{1'b0}};
            edge_q  <= {N_SRC{1'b0}};
            hwint_q <= 6'b00_0000;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            hwint_q <= hwint_d;
        end
    end

    // Combinational read mux; zero outside the decoded window.
    always_comb begin
        pr_rd = 32'h0000_0000;
        if (sel_s) begin
            case (reg_idx_s)
                REG_PEND: pr_rd = pad32(pend_q);
                REG_MASK: pr_rd = pad32(mask_q);
                REG_EDGE: pr_rd = pad32(edge_q);
                REG_VEC:  pr_rd = {vec_valid_s, 28'h000_0000, vec_idx_s};
                default:  pr_rd = 32'h0000_0000;
            endcase
        end else begin
            pr_rd = 32'h0000_0000;
        end
    end

    assign hwint   = hwint_q;
    assign irq_any = |hwint_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl. Inputs change on the falling
// edge; outputs are sampled on or just after the falling edge.
module tb_irq_ctrl;

    localparam logic [31:0] A_PEND = 32'h0000_7F30;
    localparam logic [31:0] A_MASK = 32'h0000_7F34;
    localparam logic [31:0] A_EDGE = 32'h0000_7F38;
    localparam logic [31:0] A_VEC  = 32'h0000_7F3C;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src_irq;
    logic [31:0] pr_a;
    logic        pr_we;
    logic [31:0] pr_wd;
    logic [31:0] pr_rd;
    logic [5:0]  hwint;
    logic        irq_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.N_SRC(6), .BASE(32'h0000_7F30)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .pr_a    (pr_a),
        .pr_we   (pr_we),
        .pr_wd   (pr_wd),
        .pr_rd   (pr_rd),
        .hwint   (hwint),
        .irq_any (irq_any)
    );

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        pr_a  = a;
        pr_wd = d;
        pr_we = 1'b1;
        @(negedge clk);
        pr_we = 1'b0;
        pr_wd = 32'h0000_0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        pr_a = a;
        #1;
        d = pr_rd;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        #3;
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL rst_hwint: got %h want 00", hwint); end
        checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL rst_irq_any: got %b want 0", irq_any); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_pend: got %h want 0", rd); end
        bus_read(A_MASK, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h want 0", rd); end
        bus_read(A_VEC, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_vec: got %h want 0", rd); end
        @(negedge clk);
        reset = 1'b1;
        wait_neg(1);
    endtask

    task automatic test_edge_basic;
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h01);
        bus_write(A_MASK, 32'h01);
        src_irq = 6'h01;           // N0
        @(negedge clk);            // N1 (after P1)
        src_irq = 6'h00;
        @(negedge clk);            // N2
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_pend_p2: got %h want 0", rd); end
        @(negedge clk);            // N3
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edge_pend_p3: got %h want 1", rd); end
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL edge_hwint_p3: got %h want 00", hwint); end
        @(negedge clk);            // N4
        checks++; if (hwint !== 6'h01) begin errors++; $display("FAIL edge_hwint_p4: got %h want 01", hwint); end
        checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL edge_irq_any: got %b want 1", irq_any); end
        wait_neg(3);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edge_pend_hold: got %h want 1", rd); end
        @(negedge clk);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_pend_w1c: got %h want 0", rd); end
        checks++; if (hwint !== 6'h01) begin errors++; $display("FAIL edge_hwint_w1c_1: got %h want 01", hwint); end
        @(negedge clk);
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL edge_hwint_w1c_2: got %h want 00", hwint); end
    endtask

    task automatic test_level;
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h00);
        bus_write(A_MASK, 32'h3F);
        src_irq = 6'h04;
        wait_neg(4);
        checks++; if (hwint !== 6'h04) begin errors++; $display("FAIL lvl_hwint: got %h want 04", hwint); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL lvl_pend: got %h want 4", rd); end
        @(negedge clk);
        bus_write(A_PEND, 32'h4);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL lvl_w1c_ignored: got %h want 4", rd); end
        @(negedge clk);
        src_irq = 6'h00;           // N0
        wait_neg(2);               // N2
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h4) begin errors++; $display("FAIL lvl_pend_drop_n2: got %h want 4", rd); end
        @(negedge clk);            // N3
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lvl_pend_drop_n3: got %h want 0", rd); end
        @(negedge clk);
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL lvl_hwint_drop: got %h want 00", hwint); end
    endtask

    task automatic test_vec;
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h12);
        bus_write(A_MASK, 32'h12);
        src_irq = 6'h12;
        @(negedge clk);
        src_irq = 6'h00;
        wait_neg(3);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h12) begin errors++; $display("FAIL vec_pend: got %h want 12", rd); end
        bus_read(A_VEC, rd);
        checks++; if (rd !== 32'h8000_0001) begin errors++; $display("FAIL vec_first: got %h want 80000001", rd); end
        @(negedge clk);
        bus_write(A_VEC, 32'h0);
        bus_read(A_VEC, rd);
        checks++; if (rd !== 32'h8000_0004) begin errors++; $display("FAIL vec_second: got %h want 80000004", rd); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h10) begin errors++; $display("FAIL vec_pend_after_ack: got %h want 10", rd); end
        @(negedge clk);
        bus_write(A_VEC, 32'h0);
        bus_read(A_VEC, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL vec_empty: got %h want 0", rd); end
        @(negedge clk);
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL vec_hwint: got %h want 00", hwint); end
    endtask

    task automatic test_same_cycle;
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h08);
        bus_write(A_MASK, 32'h08);
        src_irq = 6'h08;           // N0
        @(negedge clk);            // N1
        src_irq = 6'h00;
        @(negedge clk);            // N2: clear lands on P3, same edge as the rise
        bus_write(A_PEND, 32'h8);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h8) begin errors++; $display("FAIL same_cycle_pend: got %h want 8", rd); end
        wait_neg(2);
        checks++; if (hwint !== 6'h08) begin errors++; $display("FAIL same_cycle_hwint: got %h want 08", hwint); end
        bus_write(A_PEND, 32'h8);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL same_cycle_clear: got %h want 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_mask_decode;
        logic [31:0] rd;
        bus_write(A_EDGE, 32'h3F);
        bus_write(A_MASK, 32'h00);
        src_irq = 6'h3F;
        @(negedge clk);
        src_irq = 6'h00;
        wait_neg(3);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h3F) begin errors++; $display("FAIL md_pend: got %h want 3f", rd); end
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL md_hwint_masked: got %h want 00", hwint); end
        checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL md_irq_any_masked: got %b want 0", irq_any); end
        bus_read(32'h0000_7F2C, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL md_below: got %h want 0", rd); end
        bus_read(32'h0000_7F40, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL md_above: got %h want 0", rd); end
        bus_read(32'h0001_7F30, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL md_alias: got %h want 0", rd); end
        @(negedge clk);
        bus_write(32'h0000_8F34, 32'h3F);
        bus_read(A_MASK, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL md_outside_write: got %h want 0", rd); end
        @(negedge clk);
        bus_write(A_MASK, 32'hFFFF_FFFF);
        bus_read(A_MASK, rd);
        checks++; if (rd !== 32'h3F) begin errors++; $display("FAIL md_mask_upper: got %h want 3f", rd); end
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL md_hwint_w0: got %h want 00", hwint); end
        @(negedge clk);
        checks++; if (hwint !== 6'h3F) begin errors++; $display("FAIL md_hwint_w1: got %h want 3f", hwint); end
        checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL md_irq_any: got %b want 1", irq_any); end
        bus_write(A_MASK, 32'hFFFF_FFC0);
        bus_read(A_MASK, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL md_mask_hi_only: got %h want 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        bus_write(A_PEND, 32'h15);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h2A) begin errors++; $display("FAIL rm_pend_pre: got %h want 2a", rd); end
        @(negedge clk);
        bus_write(A_MASK, 32'h3F);
        @(negedge clk);
        checks++; if (hwint !== 6'h2A) begin errors++; $display("FAIL rm_hwint_pre: got %h want 2a", hwint); end
        #2;
        reset = 1'b0;              // between clock edges
        #1;
        checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL rm_hwint: got %h want 00", hwint); end
        checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL rm_irq_any: got %b want 0", irq_any); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rm_pend: got %h want 0", rd); end
        bus_read(A_MASK, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rm_mask: got %h want 0", rd); end
        bus_read(A_EDGE, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rm_edge: got %h want 0", rd); end
    endtask

    task automatic test_release_level_high;
        logic [31:0] rd;
        src_irq = 6'h20;           // held high across reset release
        @(negedge clk);            // N0
        reset = 1'b1;
        wait_neg(2);               // N2
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rel_pend_n2: got %h want 0", rd); end
        @(negedge clk);            // N3
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h20) begin errors++; $display("FAIL rel_pend_n3: got %h want 20", rd); end
        src_irq = 6'h00;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        src_irq = 6'h00;
        pr_a    = 32'h0000_0000;
        pr_we   = 1'b0;
        pr_wd   = 32'h0000_0000;
        test_reset();
        test_edge_basic();
        test_level();
        test_vec();
        test_same_cycle();
        test_mask_decode();
        test_reset_mid();
        test_release_level_high();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
